// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FP adder among NREQ requesters (IDLE/ISSUE/WAIT/RESP).
// Optional WAIT timeout enabled by defining FP_ADD_ARB_TIMEOUT_EN (adds the timeout port).
module fp_add_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned EXPBITS      = 8,
  parameter int unsigned MANTISSABITS = 23,
  parameter int unsigned TIMEOUT      = 63,
  localparam int unsigned W           = 1 + EXPBITS + MANTISSABITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      result,
  output logic              busy,
  output logic              add_go,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic              add_done,
`ifdef FP_ADD_ARB_TIMEOUT_EN
  input  logic [W-1:0]      add_result,
  output logic              timeout
`else
  input  logic [W-1:0]      add_result
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("fp_add_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] win;
  logic [IW-1:0] last;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Search from last+1 upward with wrap; candidate stays below 2*NREQ so one subtract folds it.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, last} + (IW+1)'(i + 1);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        sel_a = op_a[i*W +: W];
        sel_b = op_b[i*W +: W];
      end
    end
  end

`ifdef FP_ADD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      win        <= '0;
      last       <= IW'(NREQ - 1);
      grant      <= '0;
      resp_valid <= '0;
      result     <= '0;
      busy       <= 1'b0;
      add_go     <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
`ifdef FP_ADD_ARB_TIMEOUT_EN
      timeout    <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      grant      <= '0;
      resp_valid <= '0;
      add_go     <= 1'b0;
`ifdef FP_ADD_ARB_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found) begin
            win    <= pick;
            add_a  <= sel_a;
            add_b  <= sel_b;
            grant  <= onehot(pick);
            add_go <= 1'b1;
            busy   <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef FP_ADD_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (add_done) begin
            result     <= add_result;
            resp_valid <= onehot(win);
            state      <= S_RESP;
          end
`ifdef FP_ADD_ARB_TIMEOUT_EN
          // cnt holds completed WAIT cycles, so this fires on the TIMEOUT-th one.
          else if (cnt == CW'(TIMEOUT - 1)) begin
            result     <= '0;
            timeout    <= 1'b1;
            resp_valid <= onehot(win);
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          last  <= win;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
